// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with registered storage.
// v_o is high whenever an entry is held; yumi_i pops the head.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_param_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               push;
  logic               pop;

  function automatic logic [ptr_w-1:0] inc(
    input logic [ptr_w-1:0] p
  );
    return (p == ptr_w'(els_p - 1))
      ? '0 : p + 1'b1;
  endfunction

  assign ready_param_o = (count_r != cnt_w'(els_p));
  assign v_o           = (count_r != '0);
  assign data_o        = mem_r[rd_ptr_r];
  assign push          = v_i & ready_param_o;
  assign pop           = yumi_i & v_o;

  // storage write at the tail
  always_ff @(posedge clk_i) begin
    if (push)
      mem_r[wr_ptr_r] <= data_i;
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push)
        wr_ptr_r <= inc(wr_ptr_r);
      if (pop)
        rd_ptr_r <= inc(rd_ptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_mem_2rw_sync_driver_port.sv
// One RAM port of the driver: command pass-through, read
// credit tracking and capture of read data into a FIFO.
module bsg_mem_2rw_sync_driver_port #(
  parameter int width_p   = 32,
  parameter int els_p     = 16,
  parameter int rsp_els_p = 2,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int write_mask_width_lp = width_p >> 3
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           block_i,
  input  logic                           v_i,
  input  logic                           w_i,
  input  logic [addr_width_lp-1:0]       addr_i,
  input  logic [width_p-1:0]             data_i,
  input  logic [write_mask_width_lp-1:0] mask_i,
  output logic                           ready_and_o,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           yumi_i,
  output logic                           mem_v_o,
  output logic                           mem_w_o,
  output logic [addr_width_lp-1:0]       mem_addr_o,
  output logic [width_p-1:0]             mem_data_o,
  output logic [write_mask_width_lp-1:0] mem_mask_o,
  input  logic [width_p-1:0]             mem_data_i
);

  localparam int cnt_w = $clog2(rsp_els_p + 1);

  logic             inflight_r;
  logic [cnt_w-1:0] count_r;
  logic [cnt_w-1:0] used;
  logic             hs;
  logic             push;
  logic             pop;
  logic             fifo_ready;
  logic             fifo_v;

  // count + inflight never exceeds rsp_els_p, so it fits cnt_w
  assign used        = count_r + cnt_w'(inflight_r);
  assign ready_and_o = ~reset_i & ~block_i
                     & (used < cnt_w'(rsp_els_p));
  assign hs          = v_i & ready_and_o;

  assign mem_v_o    = hs;
  assign mem_w_o    = w_i;
  assign mem_addr_o = addr_i;
  assign mem_data_o = w_i ? data_i : '0;
  assign mem_mask_o = w_i ? mask_i : '0;

  assign push = inflight_r & fifo_ready;
  assign v_o  = fifo_v & ~reset_i;
  assign pop  = yumi_i & v_o;

  // read issued this cycle returns data next cycle
  always_ff @(posedge clk_i) begin
    if (reset_i)
      inflight_r <= 1'b0;
    else
      inflight_r <= hs & ~w_i;
  end

  // occupancy mirror used for credit accounting
  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_r <= '0;
    else
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
  end

  bsg_fifo_1r1w_small #(
    .width_p (width_p),
    .els_p   (rsp_els_p)
  ) rsp_fifo (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .v_i           (inflight_r),
    .ready_param_o (fifo_ready),
    .data_i        (mem_data_i),
    .v_o           (fifo_v),
    .data_o        (data_o),
    .yumi_i        (pop)
  );

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o
  );

endmodule

// File: rtl/bsg_mem_2rw_sync_mask_write_byte_driver.sv
// Dual-port driver for a synchronous byte-masked RAM.
// Port b yields to port a on a same-address write hazard.
module bsg_mem_2rw_sync_mask_write_byte_driver #(
  parameter int width_p   = 32,
  parameter int els_p     = 16,
  parameter int rsp_els_p = 2,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int write_mask_width_lp = width_p >> 3
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic                           a_v_i,
  input  logic                           a_w_i,
  input  logic [addr_width_lp-1:0]       a_addr_i,
  input  logic [width_p-1:0]             a_data_i,
  input  logic [write_mask_width_lp-1:0] a_mask_i,
  output logic                           a_ready_and_o,
  output logic                           a_v_o,
  output logic [width_p-1:0]             a_data_o,
  input  logic                           a_yumi_i,

  input  logic                           b_v_i,
  input  logic                           b_w_i,
  input  logic [addr_width_lp-1:0]       b_addr_i,
  input  logic [width_p-1:0]             b_data_i,
  input  logic [write_mask_width_lp-1:0] b_mask_i,
  output logic                           b_ready_and_o,
  output logic                           b_v_o,
  output logic [width_p-1:0]             b_data_o,
  input  logic                           b_yumi_i,

  output logic                           mem_a_v_o,
  output logic                           mem_a_w_o,
  output logic [addr_width_lp-1:0]       mem_a_addr_o,
  output logic [width_p-1:0]             mem_a_data_o,
  output logic [write_mask_width_lp-1:0] mem_a_mask_o,
  input  logic [width_p-1:0]             mem_a_data_i,

  output logic                           mem_b_v_o,
  output logic                           mem_b_w_o,
  output logic [addr_width_lp-1:0]       mem_b_addr_o,
  output logic [width_p-1:0]             mem_b_data_o,
  output logic [write_mask_width_lp-1:0] mem_b_mask_o,
  input  logic [width_p-1:0]             mem_b_data_i
);

  logic hazard;

  assign hazard = a_v_i & b_v_i
                & (a_addr_i == b_addr_i)
                & (a_w_i | b_w_i);

  bsg_mem_2rw_sync_driver_port #(
    .width_p   (width_p),
    .els_p     (els_p),
    .rsp_els_p (rsp_els_p)
  ) port_a (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .block_i     (1'b0),
    .v_i         (a_v_i),
    .w_i         (a_w_i),
    .addr_i      (a_addr_i),
    .data_i      (a_data_i),
    .mask_i      (a_mask_i),
    .ready_and_o (a_ready_and_o),
    .v_o         (a_v_o),
    .data_o      (a_data_o),
    .yumi_i      (a_yumi_i),
    .mem_v_o     (mem_a_v_o),
    .mem_w_o     (mem_a_w_o),
    .mem_addr_o  (mem_a_addr_o),
    .mem_data_o  (mem_a_data_o),
    .mem_mask_o  (mem_a_mask_o),
    .mem_data_i  (mem_a_data_i)
  );

  bsg_mem_2rw_sync_driver_port #(
    .width_p   (width_p),
    .els_p     (els_p),
    .rsp_els_p (rsp_els_p)
  ) port_b (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .block_i     (hazard),
    .v_i         (b_v_i),
    .w_i         (b_w_i),
    .addr_i      (b_addr_i),
    .data_i      (b_data_i),
    .mask_i      (b_mask_i),
    .ready_and_o (b_ready_and_o),
    .v_o         (b_v_o),
    .data_o      (b_data_o),
    .yumi_i      (b_yumi_i),
    .mem_v_o     (mem_b_v_o),
    .mem_w_o     (mem_b_w_o),
    .mem_addr_o  (mem_b_addr_o),
    .mem_data_o  (mem_b_data_o),
    .mem_mask_o  (mem_b_mask_o),
    .mem_data_i  (mem_b_data_i)
  );

endmodule
